// File: rtl/pipeline_hazard_control.sv
// pipeline_hazard_control: registered forwarding selects and stall/flush sequencing for the decode stage
module pipeline_hazard_control #(
   parameter int MD_TIMEOUT = 32,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [10:0]      haz,
   input  logic             load_use_stall,
   input  logic             branch_taken,
   input  logic             muldiv_start,
   input  logic             muldiv_done,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       fwd_st,
   output logic [1:0]       fwd_br,
   output logic [1:0]       fwd_r0,
   output logic [CNT_W-1:0] stall_count,
   output logic             haz_conflict,
   output logic             md_timeout
);
   localparam int MW = $clog2(MD_TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MD_WAIT} state_t;
   state_t           state_q, state_d;
   logic             skip_q, skip_d;
   logic [MW-1:0]    md_cnt_q, md_cnt_d;
   logic [9:0]       fwd_q, fwd_d, fwd_dec;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             haz_conflict_q, haz_conflict_d;
   logic             md_timeout_q, md_timeout_d;
   always_comb begin
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      md_timeout_d = md_timeout_q;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      case (state_q)
         RUN: begin
            if (branch_taken) state_d = FLUSH;
            else if (muldiv_start) begin
               state_d  = MD_WAIT;
               md_cnt_d = '0;
            end
            else if (load_use_stall && !skip_q) state_d = LU_STALL;
         end
         LU_STALL: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = branch_taken ? FLUSH : RUN;
         end
         FLUSH: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = RUN;
         end
         default: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            md_cnt_d = md_cnt_q + MW'(1);
            if (muldiv_done) state_d = RUN;
            else if (md_cnt_d == MW'(MD_TIMEOUT)) begin
               md_timeout_d = 1'b1;
               state_d      = RUN;
            end
         end
      endcase
      // one load-use stall per load: the RUN cycle right after the bubble ignores the request
      skip_d  = (state_q == LU_STALL);
      fwd_dec = {haz[6] ? 2'b01 : haz[7] ? 2'b10 : 2'b00,
                 haz[4] ? 2'b01 : haz[5] ? 2'b10 : 2'b00,
                 (haz[8] | haz[10]) ? 2'b01 : haz[9] ? 2'b10 : 2'b00,
                 haz[2] ? 2'b01 : haz[3] ? 2'b10 : 2'b00,
                 haz[1] ? 2'b01 : haz[0] ? 2'b10 : 2'b00};
      fwd_d   = id_ex_flush ? '0 : id_ex_en ? fwd_dec : fwd_q;
      stall_count_d  = (!pc_en && !(&stall_count_q)) ? stall_count_q + CNT_W'(1) : stall_count_q;
      haz_conflict_d = haz_conflict_q | (haz[0] & haz[1]) | (haz[2] & haz[3]) | (haz[4] & haz[5])
                     | (haz[6] & haz[7]) | (haz[8] & haz[9]) | (haz[8] & haz[10]) | (haz[9] & haz[10]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         skip_q         <= 1'b0;
         md_cnt_q       <= '0;
         fwd_q          <= '0;
         stall_count_q  <= '0;
         haz_conflict_q <= 1'b0;
         md_timeout_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         skip_q         <= skip_d;
         md_cnt_q       <= md_cnt_d;
         fwd_q          <= fwd_d;
         stall_count_q  <= stall_count_d;
         haz_conflict_q <= haz_conflict_d;
         md_timeout_q   <= md_timeout_d;
      end
   end
   assign fwd_a        = fwd_q[1:0];
   assign fwd_b        = fwd_q[3:2];
   assign fwd_st       = fwd_q[5:4];
   assign fwd_br       = fwd_q[7:6];
   assign fwd_r0       = fwd_q[9:8];
   assign stall_count  = stall_count_q;
   assign haz_conflict = haz_conflict_q;
   assign md_timeout   = md_timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_control.sv
// tb_pipeline_hazard_control: directed vectors for hazard control, plus a 4-bit counter instance for saturation
module tb_pipeline_hazard_control;
   logic        clk, rst_n;
   logic [10:0] haz;
   logic        lus, br, ms, md;
   logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
   logic [1:0]  fwd_a, fwd_b, fwd_st, fwd_br, fwd_r0;
   logic [15:0] stall_count;
   logic        haz_conflict, md_timeout;
   logic        s_pc_en, s_if_id_en, s_id_ex_en, s_if_id_flush, s_id_ex_flush;
   logic [1:0]  s_fwd_a, s_fwd_b, s_fwd_st, s_fwd_br, s_fwd_r0;
   logic [3:0]  s_stall_count;
   logic        s_haz_conflict, s_md_timeout;
   int          n_vec = 0, n_bad = 0;

   pipeline_hazard_control dut (
      .clk(clk), .rst_n(rst_n), .haz(haz), .load_use_stall(lus), .branch_taken(br),
      .muldiv_start(ms), .muldiv_done(md), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_en(id_ex_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st), .fwd_br(fwd_br), .fwd_r0(fwd_r0),
      .stall_count(stall_count), .haz_conflict(haz_conflict), .md_timeout(md_timeout));

   pipeline_hazard_control #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .haz(haz), .load_use_stall(lus), .branch_taken(br),
      .muldiv_start(ms), .muldiv_done(md), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
      .id_ex_en(s_id_ex_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
      .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_st(s_fwd_st), .fwd_br(s_fwd_br), .fwd_r0(s_fwd_r0),
      .stall_count(s_stall_count), .haz_conflict(s_haz_conflict), .md_timeout(s_md_timeout));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; haz = '0; lus = 0; br = 0; ms = 0; md = 0;
      #2;
      check("rst_pc_en", pc_en, 1);
      check("rst_if_id_en", if_id_en, 1);
      check("rst_id_ex_en", id_ex_en, 1);
      check("rst_flushes", {if_id_flush, id_ex_flush}, 0);
      check("rst_fwd", {fwd_a, fwd_b, fwd_st, fwd_br, fwd_r0}, 0);
      check("rst_stall_count", stall_count, 0);
      check("rst_sticky", {haz_conflict, md_timeout}, 0);
      rst_n = 1'b1;
      // forwarding priority and sticky conflict
      step; haz = 11'h003;
      step; haz = '0; #1;
      check("fwd_a_near_wins", fwd_a, 2'b01);
      check("conflict_set", haz_conflict, 1);
      step;
      check("fwd_a_idle", fwd_a, 2'b00);
      check("conflict_sticky", haz_conflict, 1);
      haz = 11'h001;
      step; haz = '0; #1;
      check("fwd_a_far", fwd_a, 2'b10);
      haz = 11'h498;
      step; haz = '0; #1;
      check("fwd_b_far", fwd_b, 2'b10);
      check("fwd_st_h10", fwd_st, 2'b01);
      check("fwd_br_near", fwd_br, 2'b01);
      check("fwd_r0_far", fwd_r0, 2'b10);
      check("fwd_a_clear", fwd_a, 2'b00);
      haz = 11'h200;
      step; haz = '0; #1;
      check("fwd_st_far", fwd_st, 2'b10);
      // load-use: one bubble, then the request is ignored for one RUN cycle
      haz = 11'h002; lus = 1; #1;
      check("lu_run_pc_en", pc_en, 1);
      step; haz = '0; #1;
      check("lu_pc_en", pc_en, 0);
      check("lu_if_id_en", if_id_en, 0);
      check("lu_id_ex_flush", id_ex_flush, 1);
      check("lu_fwd_loaded", fwd_a, 2'b01);
      step; #1;
      check("lu_skip_pc_en", pc_en, 1);
      check("lu_fwd_cleared", fwd_a, 2'b00);
      check("lu_stall_count", stall_count, 1);
      step; lus = 0; #1;
      check("lu_after_pc_en", pc_en, 1);
      check("lu_after_count", stall_count, 1);
      // branch flush, alone and together with load-use
      br = 1; #1;
      check("br_run_flush", {if_id_flush, id_ex_flush}, 0);
      step; br = 0; #1;
      check("br_flushes", {if_id_flush, id_ex_flush}, 2'b11);
      check("br_pc_en", pc_en, 1);
      step; #1;
      check("br_back_run", {pc_en, if_id_flush, id_ex_flush}, 3'b100);
      br = 1; lus = 1;
      step; br = 0; lus = 0; #1;
      check("brlu_flushes", {if_id_flush, id_ex_flush}, 2'b11);
      check("brlu_pc_en", pc_en, 1);
      step; #1;
      check("brlu_run_pc_en", pc_en, 1);
      check("brlu_stall_count", stall_count, 1);
      // multiply/divide with done after 5 wait cycles
      do_reset;
      ms = 1; #1;
      check("md_start_pc_en", pc_en, 1);
      step; ms = 0;
      for (int i = 1; i <= 5; i++) begin
         md = (i == 5); #1;
         check("md_wait_pc_en", pc_en, 0);
         check("md_wait_id_ex_en", id_ex_en, 0);
         step;
      end
      md = 0; #1;
      check("md_exit_pc_en", pc_en, 1);
      check("md_stall_count", stall_count, 5);
      check("md_no_timeout", md_timeout, 0);
      // 20 stall cycles: 16-bit counter reads 20, 4-bit counter saturates at 15
      do_reset;
      ms = 1;
      step; ms = 0;
      for (int i = 1; i <= 20; i++) begin
         md = (i == 20);
         step;
      end
      md = 0; #1;
      check("sat_wide_count", stall_count, 20);
      check("sat_narrow_count", s_stall_count, 15);
      // timeout: done never comes
      do_reset;
      ms = 1;
      step; ms = 0;
      for (int i = 1; i <= 32; i++) begin
         #1;
         check("to_wait_pc_en", pc_en, 0);
         step;
      end
      #1;
      check("to_exit_pc_en", pc_en, 1);
      check("to_md_timeout", md_timeout, 1);
      check("to_stall_count", stall_count, 32);
      step;
      check("to_sticky", md_timeout, 1);
      // async reset mid-wait with fwd_b loaded
      haz = 11'h004; ms = 1;
      step; ms = 0; haz = '0; #1;
      check("ar_fwd_b_loaded", fwd_b, 2'b01);
      check("ar_in_wait", pc_en, 0);
      step; step;
      rst_n = 1'b0; #1;
      check("ar_fwd_b", fwd_b, 2'b00);
      check("ar_enables", {pc_en, if_id_en, id_ex_en}, 3'b111);
      check("ar_stall_count", stall_count, 0);
      check("ar_sticky", {haz_conflict, md_timeout}, 0);
      rst_n = 1'b1;
      step; #1;
      check("ar_release_pc_en", pc_en, 1);
      step;
      check("ar_no_replay_pc_en", pc_en, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
